mem_access_controller: RTL and testbench

//  Bus-cycle engine on the memory side of load/store execution: the responder to the

---
 rtl/mem_access_controller_if.sv | 28 ++
 rtl/mem_access_controller.sv | 122 ++++++++++++
 tb/tb_mem_access_controller.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_controller_if.sv
// Bus bundle between the load/store requester, mem_access_controller and the external 16-bit memory.
// slave: controller side; master: requester/memory side driving requests and memory responses.
interface mem_access_controller_if;
  logic        RD_REQ;
  logic        WR_REQ;
  logic [15:0] ADDR;
  logic [15:0] WDATA;
  logic        BUSY;
  logic        DONE;
  logic [15:0] RDATA;
  logic        FAULT;
  logic [15:0] MEM_ADDR;
  logic [15:0] MEM_DOUT;
  logic [15:0] MEM_DIN;
  logic        MEM_RDN;
  logic        MEM_WRN;
  logic        MEM_READY;

  modport slave (
    input  RD_REQ, WR_REQ, ADDR, WDATA, MEM_DIN, MEM_READY,
    output BUSY, DONE, RDATA, FAULT, MEM_ADDR, MEM_DOUT, MEM_RDN, MEM_WRN
  );

  modport master (
    output RD_REQ, WR_REQ, ADDR, WDATA, MEM_DIN, MEM_READY,
    input  BUSY, DONE, RDATA, FAULT, MEM_ADDR, MEM_DOUT, MEM_RDN, MEM_WRN
  );
endinterface

// File: rtl/mem_access_controller.sv
// External memory bus-cycle engine: IDLE -> SETUP -> STROBE -> HOLD with wait states and READY stretching.
// Optional ALIGN_CHECK_EN macro rejects odd-address requests with a one-cycle FAULT pulse.
module mem_access_controller #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  mem_access_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_STATES);

  state_t      state_reg;
  logic [3:0]  wait_cnt_reg;
  logic        is_read_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        fault_reg;
  logic [15:0] rdata_reg;
  logic [15:0] mem_addr_reg;
  logic [15:0] mem_dout_reg;
  logic        mem_rdn_reg;
  logic        mem_wrn_reg;

  logic req_any;
  logic align_ok;
  logic strobe_exit;

  assign req_any = bus.RD_REQ | bus.WR_REQ;

`ifdef ALIGN_CHECK_EN
  assign align_ok = ~bus.ADDR[0];
`else
  assign align_ok = 1'b1;
`endif

  // Once READY stretching pushes the counter past the minimum, any later READY ends the strobe.
  assign strobe_exit = (wait_cnt_reg >= WAIT_LIMIT) && bus.MEM_READY;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 4'd0;
      is_read_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      fault_reg    <= 1'b0;
      rdata_reg    <= 16'h0000;
      mem_addr_reg <= 16'h0000;
      mem_dout_reg <= 16'h0000;
      mem_rdn_reg  <= 1'b1;
      mem_wrn_reg  <= 1'b1;
    end else begin
      done_reg  <= 1'b0;
      fault_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_any) begin
            if (!align_ok) begin
              fault_reg <= 1'b1;
            end else begin
              state_reg    <= SETUP;
              busy_reg     <= 1'b1;
              mem_addr_reg <= bus.ADDR;
              mem_dout_reg <= bus.WDATA;
              is_read_reg  <= bus.RD_REQ;
            end
          end
        end
        SETUP: begin
          state_reg    <= STROBE;
          wait_cnt_reg <= 4'd0;
          if (is_read_reg) begin
            mem_rdn_reg <= 1'b0;
          end else begin
            mem_wrn_reg <= 1'b0;
          end
        end
        STROBE: begin
          if (strobe_exit) begin
            state_reg   <= HOLD;
            mem_rdn_reg <= 1'b1;
            mem_wrn_reg <= 1'b1;
            done_reg    <= 1'b1;
            if (is_read_reg) begin
              rdata_reg <= bus.MEM_DIN;
            end
          end else if (wait_cnt_reg != 4'd15) begin
            wait_cnt_reg <= wait_cnt_reg + 4'd1;
          end
        end
        HOLD: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg   <= IDLE;
          busy_reg    <= 1'b0;
          mem_rdn_reg <= 1'b1;
          mem_wrn_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.BUSY     = busy_reg;
  assign bus.DONE     = done_reg;
  assign bus.FAULT    = fault_reg;
  assign bus.RDATA    = rdata_reg;
  assign bus.MEM_ADDR = mem_addr_reg;
  assign bus.MEM_DOUT = mem_dout_reg;
  assign bus.MEM_RDN  = mem_rdn_reg;
  assign bus.MEM_WRN  = mem_wrn_reg;

endmodule

// File: tb/tb_mem_access_controller.sv
// Self-checking bench: two controllers (WAIT_STATES 0 and 1) share one stimulus stream;
// a transaction-level model predicts latency, strobe length and read data.
module tb_mem_access_controller;

  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  always #5 CLK = ~CLK;

  mem_access_controller_if b0 ();
  mem_access_controller_if b1 ();

  mem_access_controller #(.WAIT_STATES(0)) dut0 (.CLK(CLK), .RESETN(RESETN), .bus(b0.slave));
  mem_access_controller #(.WAIT_STATES(1)) dut1 (.CLK(CLK), .RESETN(RESETN), .bus(b1.slave));

  assign b1.RD_REQ    = b0.RD_REQ;
  assign b1.WR_REQ    = b0.WR_REQ;
  assign b1.ADDR      = b0.ADDR;
  assign b1.WDATA     = b0.WDATA;
  assign b1.MEM_DIN   = b0.MEM_DIN;
  assign b1.MEM_READY = b0.MEM_READY;

  int sel = 0;
  logic        o_busy, o_done, o_fault, o_rdn, o_wrn;
  logic [15:0] o_rdata, o_maddr, o_mdout;

  always_comb begin
    if (sel == 0) begin
      o_busy = b0.BUSY; o_done = b0.DONE; o_fault = b0.FAULT; o_rdn = b0.MEM_RDN;
      o_wrn = b0.MEM_WRN; o_rdata = b0.RDATA; o_maddr = b0.MEM_ADDR; o_mdout = b0.MEM_DOUT;
    end else begin
      o_busy = b1.BUSY; o_done = b1.DONE; o_fault = b1.FAULT; o_rdn = b1.MEM_RDN;
      o_wrn = b1.MEM_WRN; o_rdata = b1.RDATA; o_maddr = b1.MEM_ADDR; o_mdout = b1.MEM_DOUT;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_rdata = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!b0.BUSY && !b1.BUSY) break;
      @(negedge CLK);
    end
    check("idle_before_txn", {30'd0, b1.BUSY, b0.BUSY}, 32'd0);
  endtask

  // One request on the selected controller; nlow = STROBE edges with READY held low.
  task automatic txn(input int s, input bit rd, input bit wr, input logic [15:0] addr,
                     input logic [15:0] wdata, input logic [15:0] din, input int nlow,
                     input bit pulse);
    int ws, w, done_t, busy_t, ndone, rd_low, wr_low, both, addr_bad, dout_bad, seen;
    bit busy1;
    logic [15:0] rd_at_done;
    wait_idle();
    sel = s;
    ws = (s == 0) ? 0 : 1;
    w = (nlow > ws) ? nlow : ws;
    done_t = -1; busy_t = -1; ndone = 0; rd_low = 0; wr_low = 0; both = 0;
    addr_bad = 0; dout_bad = 0; seen = 0; busy1 = 1'b0; rd_at_done = 16'hxxxx;
    b0.RD_REQ = rd; b0.WR_REQ = wr; b0.ADDR = addr; b0.WDATA = wdata;
    b0.MEM_DIN = din; b0.MEM_READY = (nlow == 0);
    for (int t = 1; t <= 60; t++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (t == 1) begin
        busy1 = o_busy;
        b0.RD_REQ = pulse; b0.WR_REQ = 1'b0;
      end else if (t == 2) begin
        b0.RD_REQ = 1'b0;
      end
      if (!o_rdn && !o_wrn) both++;
      if (!o_rdn) rd_low++;
      if (!o_wrn) wr_low++;
      if (!o_rdn || !o_wrn) begin
        seen++;
        b0.MEM_READY = (seen > nlow);
      end
      if (o_busy && o_maddr !== addr) addr_bad++;
      if (o_busy && o_mdout !== wdata) dout_bad++;
      if (o_done) begin
        ndone++;
        if (done_t < 0) begin
          done_t = t;
          rd_at_done = o_rdata;
        end
      end
      if (t > 1 && !o_busy && busy_t < 0) busy_t = t;
      if (busy_t > 0 && t >= busy_t + 3) break;
    end
    if (rd) exp_rdata = din;
    check("busy_after_accept", {31'd0, busy1}, 32'd1);
    check("done_cycle", done_t, w + 3);
    check("busy_low_cycle", busy_t, w + 4);
    check("done_count", ndone, 1);
    check("rdn_low_cycles", rd_low, rd ? w + 1 : 0);
    check("wrn_low_cycles", wr_low, (!rd && wr) ? w + 1 : 0);
    check("strobes_overlap", both, 0);
    check("mem_addr_stable", addr_bad, 0);
    check("mem_dout_stable", dout_bad, 0);
    check("rdata_at_done", {16'd0, rd_at_done}, {16'd0, exp_rdata});
    check("rdata_held", {16'd0, o_rdata}, {16'd0, exp_rdata});
    b0.MEM_READY = 1'b1;
    $display("txn dut_ws=%0d rd=%0d wr=%0d addr=%04h wdata=%04h din=%04h nlow=%0d done_t=%0d rdata=%04h",
             ws, rd, wr, addr, wdata, din, nlow, done_t, o_rdata);
  endtask

  initial begin
    int ndone, prev_t;
    logic [15:0] din_cur, a;
    bit rd, wr;

    b0.RD_REQ = 1'b0; b0.WR_REQ = 1'b0; b0.ADDR = 16'h0; b0.WDATA = 16'h0;
    b0.MEM_DIN = 16'h0; b0.MEM_READY = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_fault", {31'd0, o_fault}, 32'd0);
    check("rst_rdata", {16'd0, o_rdata}, 32'd0);
    check("rst_mem_addr", {16'd0, o_maddr}, 32'd0);
    check("rst_mem_dout", {16'd0, o_mdout}, 32'd0);
    check("rst_strobes", {30'd0, o_rdn, o_wrn}, 32'd3);
    RESETN = 1'b1;
    @(negedge CLK);

    // Read, one wait state, READY high
    txn(1, 1'b1, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 0, 1'b0);
    // Write with READY low for six strobe edges
    txn(1, 1'b0, 1'b1, 16'h0010, 16'hA5A5, 16'h0000, 6, 1'b0);
    // Read and write together, with a RD_REQ pulse while busy
    txn(1, 1'b1, 1'b1, 16'h2222, 16'h3333, 16'h4444, 0, 1'b1);
    txn(0, 1'b1, 1'b1, 16'h5554, 16'h6666, 16'h7777, 2, 1'b1);

`ifdef ALIGN_CHECK_EN
    wait_idle();
    sel = 1;
    b0.RD_REQ = 1'b1; b0.ADDR = 16'h0003; b0.MEM_DIN = 16'h1111;
    @(posedge CLK);
    @(negedge CLK);
    b0.RD_REQ = 1'b0;
    check("odd_fault", {31'd0, o_fault}, 32'd1);
    check("odd_busy", {31'd0, o_busy}, 32'd0);
    check("odd_rdn", {31'd0, o_rdn}, 32'd1);
    check("odd_done", {31'd0, o_done}, 32'd0);
    @(negedge CLK);
    check("odd_fault_pulse", {31'd0, o_fault}, 32'd0);
    check("odd_rdata", {16'd0, o_rdata}, {16'd0, exp_rdata});
    $display("txn odd address 0003 rejected fault=1");
`else
    txn(1, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h1111, 0, 1'b0);
`endif

    for (int i = 0; i < 16; i++) begin
      rd = 1'(($urandom % 2));
      wr = rd ? 1'(($urandom % 2)) : 1'b1;
      a = 16'($urandom);
`ifdef ALIGN_CHECK_EN
      a[0] = 1'b0;
`endif
      txn(int'($urandom_range(0, 1)), rd, wr, a, 16'($urandom), 16'($urandom),
          int'($urandom_range(0, 4)), 1'(($urandom % 2)));
    end

    // Reset mid-STROBE of a write
    wait_idle();
    sel = 1;
    b0.WR_REQ = 1'b1; b0.ADDR = 16'h0010; b0.WDATA = 16'hA5A5; b0.MEM_READY = 1'b0;
    @(negedge CLK);
    b0.WR_REQ = 1'b0;
    repeat (2) @(negedge CLK);
    check("pre_reset_wrn_low", {31'd0, o_wrn}, 32'd0);
    #2 RESETN = 1'b0;
    #1;
    check("async_rst_wrn", {31'd0, o_wrn}, 32'd1);
    check("async_rst_busy", {31'd0, o_busy}, 32'd0);
    check("async_rst_addr", {16'd0, o_maddr}, 32'd0);
    @(negedge CLK);
    check("rst_no_done", {31'd0, o_done}, 32'd0);
    RESETN = 1'b1; b0.MEM_READY = 1'b1;
    exp_rdata = 16'h0000;
    repeat (3) @(negedge CLK);
    check("post_rst_idle", {30'd0, o_busy, o_done}, 32'd0);
    $display("txn reset mid-strobe write addr=0010");

    txn(0, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'hCAFE, 0, 1'b0);

    // Back-to-back reads held high at 0xFFFF on the zero-wait controller
    wait_idle();
    sel = 0;
    din_cur = 16'($urandom);
    b0.RD_REQ = 1'b1; b0.ADDR = 16'hFFFF; b0.MEM_DIN = din_cur; b0.MEM_READY = 1'b1;
    ndone = 0; prev_t = -1;
    for (int t = 1; t <= 20; t++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (o_done) begin
        ndone++;
        check("b2b_rdata", {16'd0, o_rdata}, {16'd0, din_cur});
        check("b2b_addr", {16'd0, o_maddr}, 32'h0000FFFF);
        if (prev_t > 0) check("b2b_spacing", t - prev_t, 4);
        prev_t = t;
        $display("txn b2b read addr=ffff t=%0d rdata=%04h", t, o_rdata);
        din_cur = 16'($urandom);
        b0.MEM_DIN = din_cur;
      end
    end
    b0.RD_REQ = 1'b0;
    check("b2b_count", ndone, 5);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
